spi_slave: RTL and testbench

SPI slave (peripheral) endpoint, the counterpart to the team's `spi_master`. It receives SPI words from an external master on `mosi` and presents them on an AXI-Stream master port. At the same time it shifts words taken from an AXI-Stream slave port out on `miso`. It supports all four SPI modes, MSB- or LSB-first ordering, runtime word widths, and back-to-back words within one chip-select frame.

---
 rtl/spi_slave.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_spi_slave.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
// -----------------------------------------------------------------------------
// spi_slave
//   SPI peripheral endpoint. Words arriving on mosi leave on an AXI-Stream
//   master port. Words taken from an AXI-Stream slave port are shifted out on
//   miso at the same time. Supports all four SPI modes, MSB/LSB-first ordering,
//   word widths from 1 to AXIS_DATA_WIDTH, and back-to-back words within one
//   chip-select frame. Everything runs on clk. The SPI pins are synchronized,
//   and their edges are detected in the clk domain.
//
// Ports
//   clk, rst            system clock, async active-high reset
//   s_axis_t*           TX words (right-aligned) into a one-word holding buffer
//   m_axis_t*           RX words (right-aligned) from a one-word output register
//   sclk, mosi, cs_n    SPI pins from the master (asynchronous)
//   miso_o, miso_t      SPI data to the master; miso_t=1 means high-Z
//   enable              accept new frames / TX words
//   lsb_first           bit order
//   spi_mode            {CPOL, CPHA}
//   spi_word_width      bits per word; 0 means AXIS_DATA_WIDTH
//   rx_overrun_error    sticky: an unread RX word was overwritten
//   tx_underflow        1-cycle pulse: a word was started with no TX data
//   bus_active          a frame is in progress
// -----------------------------------------------------------------------------
module spi_slave #(
    parameter  int AXIS_DATA_WIDTH    = 8,
    localparam int WORD_COUNTER_WIDTH = $clog2(AXIS_DATA_WIDTH) + 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    output logic [AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    input  logic                          sclk,
    input  logic                          mosi,
    input  logic                          cs_n,
    output logic                          miso_o,
    output logic                          miso_t,
    input  logic                          enable,
    input  logic                          lsb_first,
    input  logic [1:0]                    spi_mode,
    input  logic [WORD_COUNTER_WIDTH-1:0] spi_word_width,
    output logic                          rx_overrun_error,
    output logic                          tx_underflow,
    output logic                          bus_active
);

    localparam int              W    = AXIS_DATA_WIDTH;
    localparam int              CW   = WORD_COUNTER_WIDTH;
    localparam logic [CW-1:0]   LP_W = CW'(W);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACTIVE = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Pin synchronizers plus one extra stage for edge detection.
    // The cs_n stages reset low. If cs_n is already low when reset is
    // released, no falling edge appears, so the block waits for a fresh frame.
    // ------------------------------------------------------------------
    logic r_sclk_s1, r_sclk_s2, r_sclk_d;
    logic r_mosi_s1, r_mosi_s2;
    logic r_cs_s1,   r_cs_s2,   r_cs_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sclk_s1 <= 1'b0;
            r_sclk_s2 <= 1'b0;
            r_sclk_d  <= 1'b0;
            r_mosi_s1 <= 1'b0;
            r_mosi_s2 <= 1'b0;
            r_cs_s1   <= 1'b0;
            r_cs_s2   <= 1'b0;
            r_cs_d    <= 1'b0;
        end else begin
            r_sclk_s1 <= sclk;
            r_sclk_s2 <= r_sclk_s1;
            r_sclk_d  <= r_sclk_s2;
            r_mosi_s1 <= mosi;
            r_mosi_s2 <= r_mosi_s1;
            r_cs_s1   <= cs_n;
            r_cs_s2   <= r_cs_s1;
            r_cs_d    <= r_cs_s2;
        end
    end

    logic w_sclk_rise, w_sclk_fall, w_cs_fall, w_cs_rise;
    assign w_sclk_rise = r_sclk_s2 & ~r_sclk_d;
    assign w_sclk_fall = ~r_sclk_s2 & r_sclk_d;
    assign w_cs_fall   = ~r_cs_s2 & r_cs_d;
    assign w_cs_rise   = r_cs_s2 & ~r_cs_d;

    // ------------------------------------------------------------------
    // State and per-frame configuration
    // ------------------------------------------------------------------
    state_t          r_state, w_state_nxt;
    logic            w_start;   // frame begins this cycle
    logic            w_run;     // active and not being torn down
    logic            r_cpol, r_cpha, r_lsb;
    logic [CW-1:0]   r_width;
    logic [CW-1:0]   r_bit_in_cnt, r_bit_out_cnt;
    logic [W-1:0]    r_rx_shift, r_tx_shift;
    logic [W-1:0]    r_txb_data;
    logic            r_txb_full;
    logic [W-1:0]    r_m_tdata;
    logic            r_m_tvalid, r_overrun, r_tx_underflow, r_miso;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_run       = 1'b0;
        case (r_state)
            S_IDLE: begin
                // A falling edge while disabled is consumed without effect.
                // A new frame needs cs_n to rise and fall again.
                if (w_cs_fall && enable) begin
                    w_state_nxt = S_ACTIVE;
                    w_start     = 1'b1;
                end
            end
            S_ACTIVE: begin
                if (w_cs_rise) w_state_nxt = S_IDLE;
                else           w_run       = 1'b1;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Edge roles. The sample edge is rising when CPOL^CPHA==0. The shift
    // edge is the other edge.
    // ------------------------------------------------------------------
    logic w_mode_xor, w_sample, w_shift, w_word_done;
    assign w_mode_xor  = r_cpol ^ r_cpha;
    assign w_sample    = w_run & (w_mode_xor ? w_sclk_fall : w_sclk_rise);
    assign w_shift     = w_run & (w_mode_xor ? w_sclk_rise : w_sclk_fall);
    assign w_word_done = w_sample && (CW'(r_bit_in_cnt + 1'b1) == r_width);

    // ------------------------------------------------------------------
    // TX word load. At frame start, the config inputs are used directly
    // because they are latched in the same cycle. Loads inside a frame are
    // lazy: they happen on the shift edge that needs bit 0 of the next word.
    // This way, the last word of a frame does not pull an extra buffer entry.
    // ------------------------------------------------------------------
    logic [CW-1:0] w_in_width, w_ld_width;
    logic          w_ld_lsb, w_ld_first, w_tx_load, w_tx_bit;
    logic [W-1:0]  w_ld_raw, w_ld_word, w_ld_rest, w_tx_adv;

    assign w_in_width = (spi_word_width == '0 || spi_word_width > LP_W) ? LP_W : spi_word_width;
    assign w_ld_width = (r_state == S_IDLE) ? w_in_width : r_width;
    assign w_ld_lsb   = (r_state == S_IDLE) ? lsb_first  : r_lsb;
    assign w_ld_raw   = r_txb_full ? r_txb_data : '0;
    // MSB-first words are left-aligned so the first bit always leaves from bit W-1
    assign w_ld_word  = w_ld_lsb ? w_ld_raw : (w_ld_raw << (LP_W - w_ld_width));
    assign w_ld_first = w_ld_lsb ? w_ld_word[0] : w_ld_word[W-1];
    assign w_ld_rest  = w_ld_lsb ? (w_ld_word >> 1) : (w_ld_word << 1);
    assign w_tx_load  = w_start | (w_shift & (r_bit_out_cnt == r_width));
    assign w_tx_bit   = r_lsb ? r_tx_shift[0] : r_tx_shift[W-1];
    assign w_tx_adv   = r_lsb ? (r_tx_shift >> 1) : (r_tx_shift << 1);

    // ------------------------------------------------------------------
    // RX shifter. MSB-first shifts in at bit 0. LSB-first shifts in at the
    // top, and the result is right-aligned when the word completes.
    // ------------------------------------------------------------------
    logic [W-1:0] w_rx_next, w_rx_word;
    assign w_rx_next = r_lsb ? {r_mosi_s2, r_rx_shift[W-1:1]} : {r_rx_shift[W-2:0], r_mosi_s2};
    assign w_rx_word = r_lsb ? (w_rx_next >> (LP_W - r_width)) : w_rx_next;

    // ------------------------------------------------------------------
    // Shift datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cpol         <= 1'b0;
            r_cpha         <= 1'b0;
            r_lsb          <= 1'b0;
            r_width        <= LP_W;
            r_bit_in_cnt   <= '0;
            r_bit_out_cnt  <= '0;
            r_rx_shift     <= '0;
            r_tx_shift     <= '0;
            r_miso         <= 1'b0;
            r_tx_underflow <= 1'b0;
        end else begin
            r_tx_underflow <= 1'b0;

            if (w_start) begin
                r_cpol       <= spi_mode[1];
                r_cpha       <= spi_mode[0];
                r_lsb        <= lsb_first;
                r_width      <= w_in_width;
                r_bit_in_cnt <= '0;
                r_rx_shift   <= '0;
            end else if (w_sample) begin
                if (w_word_done) begin
                    r_bit_in_cnt <= '0;
                    r_rx_shift   <= '0;
                end else begin
                    r_bit_in_cnt <= r_bit_in_cnt + 1'b1;
                    r_rx_shift   <= w_rx_next;
                end
            end

            if (w_tx_load) begin
                r_tx_underflow <= ~r_txb_full;
                if (w_start && spi_mode[0]) begin
                    // CPHA=1: the first bit waits for the leading edge
                    r_tx_shift    <= w_ld_word;
                    r_bit_out_cnt <= '0;
                    r_miso        <= 1'b0;
                end else begin
                    // CPHA=0 frame start, or any word boundary: drive bit 0 now
                    r_tx_shift    <= w_ld_rest;
                    r_miso        <= w_ld_first;
                    r_bit_out_cnt <= CW'(1);
                end
            end else if (w_shift) begin
                r_tx_shift    <= w_tx_adv;
                r_miso        <= w_tx_bit;
                r_bit_out_cnt <= r_bit_out_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // TX holding buffer. Fill and drain never coincide: a fill needs the
    // buffer empty, and a drain empties only a full buffer.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_txb_full <= 1'b0;
            r_txb_data <= '0;
        end else begin
            if (w_tx_load && r_txb_full)
                r_txb_full <= 1'b0;
            if (s_axis_tvalid && s_axis_tready) begin
                r_txb_full <= 1'b1;
                r_txb_data <= s_axis_tdata;
            end
        end
    end

    // ------------------------------------------------------------------
    // RX output register. A completed word always wins over the handshake.
    // Overrun is flagged only if the old word was not taken in this cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_m_tdata  <= '0;
            r_m_tvalid <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            if (r_m_tvalid && m_axis_tready) begin
                r_m_tvalid <= 1'b0;
                r_overrun  <= 1'b0;
            end
            if (w_word_done) begin
                r_m_tdata  <= w_rx_word;
                r_m_tvalid <= 1'b1;
                if (r_m_tvalid && !m_axis_tready)
                    r_overrun <= 1'b1;
            end
        end
    end

    assign s_axis_tready    = enable & ~r_txb_full;
    assign m_axis_tdata     = r_m_tdata;
    assign m_axis_tvalid    = r_m_tvalid;
    assign rx_overrun_error = r_overrun;
    assign tx_underflow     = r_tx_underflow;
    assign miso_o           = r_miso;
    // Decoded from state, so an async reset floats miso at once
    assign miso_t           = (r_state != S_ACTIVE);
    assign bus_active       = (r_state == S_ACTIVE);

endmodule

// File: tb/tb_spi_slave.sv
// -----------------------------------------------------------------------------
// tb_spi_slave
//   Self-checking bench for spi_slave. A behavioural SPI master drives the
//   pins. Expected RX beats and expected miso words are queued when stimulus
//   is set up. They are compared when the DUT produces m_axis beats or the
//   master finishes a word.
// -----------------------------------------------------------------------------
module tb_spi_slave;

    localparam int W  = 8;
    localparam int HP = 8;   // sclk half period in clk cycles

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] s_axis_tdata;
    logic       s_axis_tvalid, s_axis_tready;
    logic [7:0] m_axis_tdata;
    logic       m_axis_tvalid, m_axis_tready;
    logic       sclk, mosi, cs_n, miso_o, miso_t, enable, lsb_first;
    logic [1:0] spi_mode;
    logic [3:0] spi_word_width;
    logic       rx_overrun_error, tx_underflow, bus_active;

    logic [7:0] exp_rx[$];
    logic [7:0] exp_tx[$];
    logic [7:0] mosi_q[$];
    int         n_chk = 0;
    int         n_err = 0;
    int         uf_cnt = 0;
    int         uf0;
    bit         mon_en = 1'b1;

    always #5 clk = ~clk;

    spi_slave #(.AXIS_DATA_WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .sclk(sclk), .mosi(mosi), .cs_n(cs_n), .miso_o(miso_o), .miso_t(miso_t),
        .enable(enable), .lsb_first(lsb_first), .spi_mode(spi_mode), .spi_word_width(spi_word_width),
        .rx_overrun_error(rx_overrun_error), .tx_underflow(tx_underflow), .bus_active(bus_active)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
        end
    endtask

    // RX scoreboard and underflow pulse counter
    initial forever begin
        @(negedge clk);
        if (mon_en && m_axis_tvalid && m_axis_tready) begin
            if (exp_rx.size() == 0) chk("rx_extra_beat", 32'(exp_rx.size()), 32'd1);
            else                    chk("rx_data", 32'(m_axis_tdata), 32'(exp_rx.pop_front()));
        end
        if (tx_underflow) uf_cnt++;
    end

    initial begin
        #500us;
        $display("FAIL watchdog: time limit reached, summary not reached");
        $fatal(1);
    end

    task automatic push_tx(input logic [7:0] d);
        int t = 0;
        @(negedge clk);
        s_axis_tdata  = d;
        s_axis_tvalid = 1'b1;
        while (!s_axis_tready && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 5000) chk("tx_accept_timeout", 32'(t), 32'd0);
        @(posedge clk);
        #1 s_axis_tvalid = 1'b0;
    endtask

    // SPI master: nw words from mosi_q. Each completed miso word is compared
    // with exp_tx. abort_bits>0 raises cs_n after that many bits.
    task automatic spi_xfer(input logic [1:0] mode, input logic lsb, input int w,
                            input int nw, input int abort_bits);
        logic [7:0] mw, rw;
        int         idx;
        int         nb = 0;
        bit         stop = 1'b0;
        spi_mode       = mode;
        lsb_first      = lsb;
        spi_word_width = 4'(w);
        sclk           = mode[1];
        repeat (HP) @(negedge clk);
        cs_n = 1'b0;
        if (mode[0]) repeat (HP) @(negedge clk);
        for (int wd = 0; wd < nw && !stop; wd++) begin
            mw = mosi_q.pop_front();
            rw = '0;
            for (int k = 0; k < w && !stop; k++) begin
                idx = lsb ? k : w - 1 - k;
                if (!mode[0]) begin
                    mosi = mw[idx];
                    repeat (HP) @(negedge clk);
                    if (wd == 0 && k == 0) chk("bus_active_frame", 32'(bus_active), 32'd1);
                    rw[idx] = miso_o;
                    sclk = ~sclk;
                    repeat (HP) @(negedge clk);
                    sclk = ~sclk;
                end else begin
                    sclk = ~sclk;
                    mosi = mw[idx];
                    repeat (HP) @(negedge clk);
                    if (wd == 0 && k == 0) chk("bus_active_frame", 32'(bus_active), 32'd1);
                    rw[idx] = miso_o;
                    sclk = ~sclk;
                    repeat (HP) @(negedge clk);
                end
                nb++;
                if (abort_bits != 0 && nb == abort_bits) stop = 1'b1;
            end
            if (!stop) begin
                if (exp_tx.size() == 0) chk("miso_extra_word", 32'(exp_tx.size()), 32'd1);
                else                    chk("miso_word", 32'(rw), 32'(exp_tx.pop_front()));
            end
        end
        repeat (HP) @(negedge clk);
        cs_n = 1'b1;
        repeat (2 * HP) @(negedge clk);
    endtask

    initial begin
        enable         = 1'b1;
        cs_n           = 1'b1;
        sclk           = 1'b0;
        mosi           = 1'b0;
        s_axis_tvalid  = 1'b0;
        s_axis_tdata   = '0;
        m_axis_tready  = 1'b1;
        spi_mode       = 2'd0;
        lsb_first      = 1'b0;
        spi_word_width = 4'd8;
        #1 rst = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // reset state
        chk("rst_tready",   32'(s_axis_tready),    32'd1);
        chk("rst_tvalid",   32'(m_axis_tvalid),    32'd0);
        chk("rst_tdata",    32'(m_axis_tdata),     32'd0);
        chk("rst_miso_t",   32'(miso_t),           32'd1);
        chk("rst_miso_o",   32'(miso_o),           32'd0);
        chk("rst_active",   32'(bus_active),       32'd0);
        chk("rst_overrun",  32'(rx_overrun_error), 32'd0);
        chk("rst_underflow",32'(tx_underflow),     32'd0);

        // mode 0, MSB-first, width 8
        push_tx(8'hA5);
        exp_tx.push_back(8'hA5);
        mosi_q.push_back(8'h3C);
        exp_rx.push_back(8'h3C);
        spi_xfer(2'd0, 1'b0, 8, 1, 0);
        chk("bus_active_idle", 32'(bus_active), 32'd0);
        chk("rx_pending_m0", 32'(exp_rx.size()), 32'd0);

        // every mode x bit order, width 5
        for (int m = 0; m < 4; m++) begin
            for (int l = 0; l < 2; l++) begin
                push_tx(8'h13);
                exp_tx.push_back(8'h13);
                mosi_q.push_back(8'h0B);
                exp_rx.push_back(8'h0B);
                spi_xfer(2'(m), 1'(l), 5, 1, 0);
            end
        end
        chk("rx_pending_modes", 32'(exp_rx.size()), 32'd0);

        // back-to-back words in one frame, TX refilled as it drains
        uf0 = uf_cnt;
        push_tx(8'h11);
        for (int i = 1; i <= 3; i++) begin
            exp_tx.push_back(8'(8'h11 * i));
            mosi_q.push_back(8'(8'h11 * i));
            exp_rx.push_back(8'(8'h11 * i));
        end
        fork
            begin
                push_tx(8'h22);
                push_tx(8'h33);
            end
            spi_xfer(2'd1, 1'b0, 8, 3, 0);
        join
        chk("b2b_underflow", 32'(uf_cnt - uf0), 32'd0);
        chk("rx_pending_b2b", 32'(exp_rx.size()), 32'd0);

        // TX underflow: empty buffer at frame start
        uf0 = uf_cnt;
        exp_tx.push_back(8'h00);
        mosi_q.push_back(8'h5A);
        exp_rx.push_back(8'h5A);
        spi_xfer(2'd1, 1'b1, 8, 1, 0);
        chk("underflow_pulses", 32'(uf_cnt - uf0), 32'd1);

        // RX overrun: two words with nobody reading
        mon_en        = 1'b0;
        m_axis_tready = 1'b0;
        exp_tx.push_back(8'h00);
        exp_tx.push_back(8'h00);
        mosi_q.push_back(8'h81);
        mosi_q.push_back(8'h7E);
        spi_xfer(2'd3, 1'b0, 8, 2, 0);
        chk("ovr_tvalid",  32'(m_axis_tvalid),    32'd1);
        chk("ovr_tdata",   32'(m_axis_tdata),     32'h7E);
        chk("ovr_flag",    32'(rx_overrun_error), 32'd1);
        m_axis_tready = 1'b1;
        @(negedge clk);
        chk("ovr_tvalid_clr", 32'(m_axis_tvalid),    32'd0);
        chk("ovr_flag_clr",   32'(rx_overrun_error), 32'd0);
        mon_en = 1'b1;

        // abort after 4 bits: no beat, buffer kept for the next frame
        push_tx(8'hC3);
        mosi_q.push_back(8'h0F);
        fork
            push_tx(8'h5C);
            spi_xfer(2'd1, 1'b0, 8, 1, 4);
        join
        chk("abort_active", 32'(bus_active),    32'd0);
        chk("abort_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("abort_buf_full", 32'(s_axis_tready), 32'd0);
        exp_tx.push_back(8'h5C);
        mosi_q.push_back(8'h66);
        exp_rx.push_back(8'h66);
        spi_xfer(2'd1, 1'b0, 8, 1, 0);
        chk("rx_pending_abort", 32'(exp_rx.size()), 32'd0);

        // cs_n falling while disabled is ignored, even after re-enable
        enable = 1'b0;
        @(negedge clk);
        chk("dis_tready", 32'(s_axis_tready), 32'd0);
        sclk = 1'b0;
        cs_n = 1'b0;
        repeat (10) @(negedge clk);
        chk("dis_active", 32'(bus_active), 32'd0);
        enable = 1'b1;
        repeat (10) @(negedge clk);
        chk("dis_still_idle", 32'(bus_active), 32'd0);
        cs_n = 1'b1;
        repeat (10) @(negedge clk);

        // async reset mid-word
        push_tx(8'hE7);
        spi_mode       = 2'd0;
        lsb_first      = 1'b0;
        spi_word_width = 4'd8;
        cs_n = 1'b0;
        repeat (HP) @(negedge clk);
        sclk = 1'b1;
        repeat (HP) @(negedge clk);
        sclk = 1'b0;
        repeat (HP) @(negedge clk);
        chk("mid_active", 32'(bus_active), 32'd1);
        chk("mid_miso_t", 32'(miso_t),     32'd0);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_miso_t", 32'(miso_t),     32'd1);
        chk("rst_async_active", 32'(bus_active), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst2_tready",   32'(s_axis_tready),    32'd1);
        chk("rst2_tvalid",   32'(m_axis_tvalid),    32'd0);
        chk("rst2_miso_o",   32'(miso_o),           32'd0);
        chk("rst2_overrun",  32'(rx_overrun_error), 32'd0);
        chk("rst2_underflow",32'(tx_underflow),     32'd0);
        // cs_n is still low: clocks must not restart the frame
        for (int i = 0; i < 4; i++) begin
            sclk = ~sclk;
            repeat (HP) @(negedge clk);
        end
        chk("rst2_wait_cs", 32'(bus_active), 32'd0);
        cs_n = 1'b1;
        repeat (2 * HP) @(negedge clk);

        // normal frame after recovery
        push_tx(8'h3C);
        exp_tx.push_back(8'h3C);
        mosi_q.push_back(8'hA5);
        exp_rx.push_back(8'hA5);
        spi_xfer(2'd0, 1'b0, 8, 1, 0);
        chk("rx_pending_final", 32'(exp_rx.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
